// File: rtl/vanilla_pc_event_coalescer_if.sv
// Record stream carrying coalesced (pc, event, count) runs from the coalescer
// to a trace sink or histogram memory.
//   v           record valid (producer -> sink)
//   pc          record PC
//   evt         record event code
//   count       run length in cycles (>= 1)
//   ready       sink accepts the record when v & ready (sink -> producer)
//   start_cycle cycle the run opened (only with VANILLA_PC_EVENT_COALESCER_TIMESTAMP_EN)
// Modports: master = record producer, slave = record sink.
interface vanilla_pc_event_coalescer_if #(
    parameter int unsigned pc_width_p    = 32,
    parameter int unsigned event_width_p = 5,
    parameter int unsigned count_width_p = 16
);
    logic                     v;
    logic [pc_width_p-1:0]    pc;
    logic [event_width_p-1:0] evt;
    logic [count_width_p-1:0] count;
    logic                     ready;
`ifdef VANILLA_PC_EVENT_COALESCER_TIMESTAMP_EN
    logic [31:0]              start_cycle;

    modport master (output v, pc, evt, count, start_cycle, input ready);
    modport slave  (input v, pc, evt, count, start_cycle, output ready);
`else
    modport master (output v, pc, evt, count, input ready);
    modport slave  (input v, pc, evt, count, output ready);
`endif
endinterface

// File: rtl/vanilla_pc_event_coalescer.sv
// Run-length coalescer for classified (pc, event) samples. Consecutive
// identical samples collapse into one (pc, event, count) record; records are
// buffered in a small FIFO and drained over a valid/ready stream.
// Optional macro VANILLA_PC_EVENT_COALESCER_TIMESTAMP_EN adds a free-running
// 32-bit cycle counter captured at run open and carried on rec_o.start_cycle.
// Ports:
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   v_i, pc_i, event_i sample valid / PC / event code
//   flush_i            close the current run and push it
//   rec_o              record stream (master side)
//   drop_count_o       saturating count of records lost to a full FIFO
//   idle_o             no open run, no pending flush, FIFO empty
module vanilla_pc_event_coalescer #(
    parameter int unsigned pc_width_p         = 32,
    parameter int unsigned event_width_p      = 5,
    parameter int unsigned count_width_p      = 16,
    parameter int unsigned fifo_els_p         = 4,
    parameter int unsigned drop_count_width_p = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          v_i,
    input  logic [pc_width_p-1:0]         pc_i,
    input  logic [event_width_p-1:0]      event_i,
    input  logic                          flush_i,
    vanilla_pc_event_coalescer_if.master  rec_o,
    output logic [drop_count_width_p-1:0] drop_count_o,
    output logic                          idle_o
);
    localparam int unsigned addr_width_lp = $clog2(fifo_els_p);
    localparam int unsigned ptr_width_lp  = addr_width_lp + 1;
    localparam logic [count_width_p-1:0]      cnt_max_lp  = '1;
    localparam logic [drop_count_width_p-1:0] drop_max_lp = '1;

    typedef struct packed {
`ifdef VANILLA_PC_EVENT_COALESCER_TIMESTAMP_EN
        logic [31:0]              ts;
`endif
        logic [pc_width_p-1:0]    pc;
        logic [event_width_p-1:0] evt;
        logic [count_width_p-1:0] cnt;
    } rec_t;

    logic                          run_v_q, run_v_n;
    rec_t                          run_q, run_n;
    logic                          flush_pend_q, flush_pend_n;
    rec_t                          open_rec_c;
    logic                          push_c;
    logic                          match_c;

    rec_t                          mem_q [fifo_els_p];
    logic [ptr_width_lp-1:0]       wr_ptr_q, rd_ptr_q;
    logic                          empty_c, full_c, pop_c, wr_en_c, drop_c;
    rec_t                          head_c;
    logic [drop_count_width_p-1:0] drop_q;

`ifdef VANILLA_PC_EVENT_COALESCER_TIMESTAMP_EN
    logic [31:0]                   cyc_q;

    // Free-running cycle counter, wraps naturally
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) cyc_q <= '0;
        else            cyc_q <= cyc_q + 32'd1;
    end
`endif

    // Record for a run opened by the current sample
    always_comb begin
        open_rec_c     = '0;
        open_rec_c.pc  = pc_i;
        open_rec_c.evt = event_i;
        open_rec_c.cnt = count_width_p'(1);
`ifdef VANILLA_PC_EVENT_COALESCER_TIMESTAMP_EN
        open_rec_c.ts  = cyc_q;
`endif
    end

    assign match_c = (pc_i == run_q.pc) && (event_i == run_q.evt);

    // Run-length / flush decisions; the pushed record is always the old run
    always_comb begin
        run_v_n      = run_v_q;
        run_n        = run_q;
        flush_pend_n = flush_pend_q;
        push_c       = 1'b0;
        if (v_i) begin
            if (!run_v_q) begin
                run_v_n = 1'b1;
                run_n   = open_rec_c;
            end else if (match_c && (run_q.cnt != cnt_max_lp)) begin
                run_n.cnt = run_q.cnt + count_width_p'(1);
            end else begin
                // Mismatch or saturated run: close it, the sample opens the next
                push_c = 1'b1;
                run_n  = open_rec_c;
            end
            // A flush alongside a sample waits for the first idle cycle
            if (flush_i) flush_pend_n = 1'b1;
        end else if (flush_i || flush_pend_q) begin
            push_c       = run_v_q;
            run_v_n      = 1'b0;
            flush_pend_n = 1'b0;
        end
    end

    // Run register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            run_v_q      <= 1'b0;
            run_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            run_v_q      <= run_v_n;
            run_q        <= run_n;
            flush_pend_q <= flush_pend_n;
        end
    end

    // FIFO status; a pop in the same cycle frees a slot for a push when full
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = ((wr_ptr_q - rd_ptr_q) == ptr_width_lp'(fifo_els_p));
    assign pop_c   = !empty_c && rec_o.ready;
    assign wr_en_c = push_c && (!full_c || pop_c);
    assign drop_c  = push_c && full_c && !pop_c;

    // Record storage, no reset needed since the head is gated by empty
    always_ff @(posedge clk_i) begin
        if (wr_en_c) mem_q[wr_ptr_q[addr_width_lp-1:0]] <= run_q;
    end

    // Pointers and saturating drop counter
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= '0;
        end else begin
            if (wr_en_c) wr_ptr_q <= wr_ptr_q + ptr_width_lp'(1);
            if (pop_c)   rd_ptr_q <= rd_ptr_q + ptr_width_lp'(1);
            if (drop_c && (drop_q != drop_max_lp)) drop_q <= drop_q + drop_count_width_p'(1);
        end
    end

    // Head of FIFO, forced to zero when nothing is queued
    always_comb begin
        head_c = '0;
        if (!empty_c) head_c = mem_q[rd_ptr_q[addr_width_lp-1:0]];
    end

    assign rec_o.v     = !empty_c;
    assign rec_o.pc    = head_c.pc;
    assign rec_o.evt   = head_c.evt;
    assign rec_o.count = head_c.cnt;
`ifdef VANILLA_PC_EVENT_COALESCER_TIMESTAMP_EN
    assign rec_o.start_cycle = head_c.ts;
`endif
    assign drop_count_o = drop_q;
    assign idle_o       = !run_v_q && !flush_pend_q && empty_c;

endmodule

// File: tb/tb_vanilla_pc_event_coalescer.sv
module tb_vanilla_pc_event_coalescer;
    localparam int unsigned PCW  = 32;
    localparam int unsigned EW   = 5;
    localparam int unsigned CW   = 4;
    localparam int unsigned FE   = 4;
    localparam int unsigned DW   = 3;
    localparam int          CMAX = 15;
    localparam int          DMAX = 7;

    logic            clk_i = 1'b0;
    logic            reset_n_i = 1'b0;
    logic            v_i = 1'b0;
    logic [PCW-1:0]  pc_i = '0;
    logic [EW-1:0]   event_i = '0;
    logic            flush_i = 1'b0;
    logic [DW-1:0]   drop_count_o;
    logic            idle_o;

    vanilla_pc_event_coalescer_if #(.pc_width_p(PCW), .event_width_p(EW), .count_width_p(CW)) rec_if ();

    vanilla_pc_event_coalescer #(
        .pc_width_p(PCW), .event_width_p(EW), .count_width_p(CW),
        .fifo_els_p(FE), .drop_count_width_p(DW)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .pc_i(pc_i),
        .event_i(event_i), .flush_i(flush_i), .rec_o(rec_if),
        .drop_count_o(drop_count_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  evt;
        int          cnt;
        logic [31:0] ts;
    } trec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: open run, pending flush, record queue, drop counter
    trec_t       mq[$];
    trec_t       got[$];
    bit          m_run_v;
    trec_t       m_run;
    bit          m_fp;
    int          m_drop;
    logic [31:0] m_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_run_v = 0;
        m_run   = '{pc: '0, evt: '0, cnt: 0, ts: '0};
        m_fp    = 0;
        m_drop  = 0;
        m_cyc   = '0;
    endtask

    // Model update on each active edge, using the inputs seen at that edge
    initial begin
        m_reset();
        forever begin
            @(posedge clk_i or negedge reset_n_i);
            if (!reset_n_i) begin
                m_reset();
            end else begin : step_blk
                bit    do_push;
                trec_t pr;
                trec_t nr;
                do_push = 0;
                pr = m_run;
                nr = '{pc: pc_i, evt: event_i, cnt: 1, ts: m_cyc};
                if (v_i) begin
                    if (!m_run_v) begin
                        m_run_v = 1;
                        m_run   = nr;
                    end else if (pc_i == m_run.pc && event_i == m_run.evt && m_run.cnt < CMAX) begin
                        m_run.cnt = m_run.cnt + 1;
                    end else begin
                        do_push = 1;
                        m_run   = nr;
                    end
                    if (flush_i) m_fp = 1;
                end else if (flush_i || m_fp) begin
                    if (m_run_v) do_push = 1;
                    m_run_v = 0;
                    m_fp    = 0;
                end
                if (mq.size() != 0 && rec_if.ready) void'(mq.pop_front());
                if (do_push) begin
                    if (mq.size() < FE) mq.push_back(pr);
                    else if (m_drop < DMAX) m_drop = m_drop + 1;
                end
                m_cyc = m_cyc + 32'd1;
            end
        end
    end

    // Per-cycle compare against the model, plus capture of accepted records
    initial begin
        forever begin
            @(negedge clk_i);
            if (reset_n_i) begin : cmp_blk
                trec_t r;
                chk("v_o", 64'(rec_if.v), 64'(mq.size() != 0));
                if (mq.size() != 0) begin
                    chk("pc_o", 64'(rec_if.pc), 64'(mq[0].pc));
                    chk("event_o", 64'(rec_if.evt), 64'(mq[0].evt));
                    chk("count_o", 64'(rec_if.count), 64'(mq[0].cnt));
`ifdef VANILLA_PC_EVENT_COALESCER_TIMESTAMP_EN
                    chk("start_cycle_o", 64'(rec_if.start_cycle), 64'(mq[0].ts));
`endif
                end else begin
                    chk("pc_o_empty", 64'(rec_if.pc), 64'(0));
                    chk("count_o_empty", 64'(rec_if.count), 64'(0));
                end
                chk("drop_count_o", 64'(drop_count_o), 64'(m_drop));
                chk("idle_o", 64'(idle_o), 64'(!m_run_v && !m_fp && mq.size() == 0));
                if (rec_if.v && rec_if.ready) begin
                    r = '{pc: rec_if.pc, evt: rec_if.evt, cnt: int'(rec_if.count), ts: '0};
                    got.push_back(r);
                end
            end
        end
    end

    task automatic step(input bit v, input logic [31:0] pc, input logic [4:0] e,
                        input bit fl, input bit rdy);
        v_i = v; pc_i = pc; event_i = e; flush_i = fl; rec_if.ready = rdy;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_got(input string name, input int idx, input logic [31:0] pc,
                           input logic [4:0] e, input int cnt);
        if (idx >= got.size()) begin
            chk({name, "_present"}, 64'(got.size()), 64'(idx + 1));
        end else begin
            chk({name, "_pc"}, 64'(got[idx].pc), 64'(pc));
            chk({name, "_evt"}, 64'(got[idx].evt), 64'(e));
            chk({name, "_cnt"}, 64'(got[idx].cnt), 64'(cnt));
        end
    endtask

    initial begin
        logic [31:0] cur_pc;
        logic [4:0]  cur_e;
        int          mode;
        rec_if.ready = 1'b0;
        #13;
        chk("rst_v_o", 64'(rec_if.v), 64'(0));
        chk("rst_idle_o", 64'(idle_o), 64'(1));
        chk("rst_drop", 64'(drop_count_o), 64'(0));
        chk("rst_pc_o", 64'(rec_if.pc), 64'(0));
        @(negedge clk_i); #2 reset_n_i = 1'b1;
        @(posedge clk_i); #1;

        // Basic run of five then a new PC
        for (int i = 0; i < 5; i++) step(1, 32'h100, 5'd0, 0, 1);
        step(1, 32'h104, 5'd0, 0, 1);
        chk("t1_v_o", 64'(rec_if.v), 64'(1));
        chk("t1_pc_o", 64'(rec_if.pc), 64'(32'h100));
        chk("t1_count_o", 64'(rec_if.count), 64'(5));
        chk("t1_drop", 64'(drop_count_o), 64'(0));
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        chk("t1_nrec", 64'(got.size()), 64'(2));
        chk_got("t1_r0", 0, 32'h100, 5'd0, 5);
        chk_got("t1_r1", 1, 32'h104, 5'd0, 1);
        got.delete();

        // Saturated run splits at 15
        for (int i = 0; i < 20; i++) step(1, 32'h200, 5'd3, 0, 1);
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        chk("t2_nrec", 64'(got.size()), 64'(2));
        chk_got("t2_r0", 0, 32'h200, 5'd3, 15);
        chk_got("t2_r1", 1, 32'h200, 5'd3, 5);
        got.delete();

        // Backpressure: 6 runs into a 4-deep FIFO
        for (int i = 0; i < 6; i++) step(1, (i % 2 == 0) ? 32'h0 : 32'h4, 5'd0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("t3_drop", 64'(drop_count_o), 64'(2));
        chk("t3_model_drop", 64'(m_drop), 64'(2));
        chk("t3_v_o", 64'(rec_if.v), 64'(1));
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        chk("t3_nrec", 64'(got.size()), 64'(4));
        chk_got("t3_r0", 0, 32'h0, 5'd0, 1);
        chk_got("t3_r1", 1, 32'h4, 5'd0, 1);
        chk_got("t3_r2", 2, 32'h0, 5'd0, 1);
        chk_got("t3_r3", 3, 32'h4, 5'd0, 1);
        got.delete();

        // Flush alongside a sample is deferred
        step(1, 32'h300, 5'd1, 0, 1);
        step(1, 32'h300, 5'd1, 0, 1);
        step(1, 32'h300, 5'd1, 1, 1);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        chk("t4_nrec", 64'(got.size()), 64'(1));
        chk_got("t4_r0", 0, 32'h300, 5'd1, 3);
        chk("t4_idle", 64'(idle_o), 64'(1));
        got.delete();

        // Asynchronous reset with queued records and an open run
        step(1, 32'h10, 5'd0, 0, 0);
        step(1, 32'h14, 5'd0, 0, 0);
        step(1, 32'h18, 5'd0, 0, 0);
        step(1, 32'h1c, 5'd0, 0, 0);
        chk("t5_pre_v_o", 64'(rec_if.v), 64'(1));
        #3 reset_n_i = 1'b0;
        #1;
        chk("t5_rst_v_o", 64'(rec_if.v), 64'(0));
        chk("t5_rst_idle", 64'(idle_o), 64'(1));
        chk("t5_rst_drop", 64'(drop_count_o), 64'(0));
        v_i = 1'b0;
        @(negedge clk_i); #2 reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        got.delete();
        step(1, 32'h500, 5'd2, 0, 1);
        step(1, 32'h500, 5'd2, 0, 1);
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        chk("t5_nrec", 64'(got.size()), 64'(1));
        chk_got("t5_r0", 0, 32'h500, 5'd2, 2);
        got.delete();

        // Randomized traffic against the model
        cur_pc = 32'h40;
        cur_e  = 5'd0;
        mode   = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) mode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) begin
                cur_pc = 32'h40 + 32'($urandom_range(0, 2)) * 32'h4;
                cur_e  = 5'($urandom_range(0, 1));
            end
            step($urandom_range(0, 9) < 7, cur_pc, cur_e, $urandom_range(0, 19) == 0,
                 (mode == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8));
        end

        // Final drain, bounded
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 50 && !idle_o; i++) step(0, 0, 0, 0, 1);
        chk("final_idle", 64'(idle_o), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
